// File: rtl/mem_arbiter.sv
// Two-port (icache/dcache) arbiter in front of a single cache-line memory port.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin ties; otherwise p1 (dcache) wins ties.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 256,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_req_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic [DATA_W-1:0] p0_data_o,
  output logic              p0_ack_o,
  input  logic              p1_req_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_reg, state_next;
  logic              grant_reg, grant_next;
  logic              write_reg, write_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              tflag_reg, tflag_next;

  logic [1:0]        req;
  logic [1:0]        write_vec;
  logic [ADDR_W-1:0] addr_vec [2];
  logic [DATA_W-1:0] data_vec [2];
  logic [DATA_W-1:0] rdata_reg [2];
  logic [1:0]        ack_vec;
  logic              grant_sel;
  logic              active;
  logic [CNT_W-1:0]  cnt_inc;

  assign req       = {p1_req_i, p0_req_i};
  assign write_vec = {p1_write_i, p0_write_i};
  assign addr_vec[0] = p0_addr_i;
  assign addr_vec[1] = p1_addr_i;
  assign data_vec[0] = p0_data_i;
  assign data_vec[1] = p1_data_i;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // Reset value 1 makes p0 the winner of the first tie.
  logic last_grant_reg;

  always_comb begin
    if (req[0] && req[1]) grant_sel = ~last_grant_reg;
    else                  grant_sel = req[1];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_grant_reg <= 1'b1;
    end else if (state_reg == S_IDLE && (|req)) begin
      last_grant_reg <= grant_sel;
    end
  end
`else
  assign grant_sel = req[1];
`endif

  // The counter only advances while in WAIT and leaves at CNT_LIMIT, so it never wraps.
  assign cnt_inc = cnt_reg + CNT_W'(1);

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    write_next = write_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    cnt_next   = cnt_reg;
    tflag_next = tflag_reg;
    case (state_reg)
      S_IDLE: begin
        if (|req) begin
          state_next = S_ISSUE;
          grant_next = grant_sel;
          write_next = write_vec[grant_sel];
          addr_next  = addr_vec[grant_sel];
          wdata_next = data_vec[grant_sel];
          tflag_next = 1'b0;
        end
      end
      S_ISSUE: begin
        state_next = S_WAIT;
        cnt_next   = '0;
      end
      S_WAIT: begin
        cnt_next = cnt_inc;
        if (mem_ack_i) begin
          state_next = S_DONE;
        end else if (cnt_inc == CNT_LIMIT) begin
          state_next = S_DONE;
          tflag_next = 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
        tflag_next = 1'b0;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= S_IDLE;
      grant_reg <= 1'b0;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      cnt_reg   <= '0;
      tflag_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      write_reg <= write_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      cnt_reg   <= cnt_next;
      tflag_reg <= tflag_next;
    end
  end

  // Per-requester read-data holding registers and ack decode.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign ack_vec[gi] = (state_reg == S_DONE) && (grant_reg == 1'(gi));

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        rdata_reg[gi] <= '0;
      end else if (state_reg == S_WAIT && mem_ack_i && !write_reg
                   && grant_reg == 1'(gi)) begin
        rdata_reg[gi] <= mem_data_i;
      end
    end
  end

  assign active       = (state_reg == S_ISSUE) || (state_reg == S_WAIT);
  assign mem_enable_o = (state_reg == S_ISSUE);
  assign mem_write_o  = active && write_reg;
  assign mem_addr_o   = active ? addr_reg  : '0;
  assign mem_data_o   = active ? wdata_reg : '0;
  assign busy_o       = (state_reg != S_IDLE);
  assign timeout_o    = (state_reg == S_DONE) && tflag_reg;
  assign p0_ack_o     = ack_vec[0];
  assign p1_ack_o     = ack_vec[1];
  assign p0_data_o    = rdata_reg[0];
  assign p1_data_o    = rdata_reg[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT_CYC = 8).
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          p0_req_i, p0_write_i, p1_req_i, p1_write_i;
  logic [AW-1:0] p0_addr_i, p1_addr_i;
  logic [DW-1:0] p0_data_i, p1_data_i, p0_data_o, p1_data_o;
  logic          p0_ack_o, p1_ack_o;
  logic          mem_enable_o, mem_write_o, mem_ack_i, busy_o, timeout_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o, mem_data_i;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int p1_ack_cnt = 0;

  logic          cap_write, wait_write;
  logic [AW-1:0] cap_addr, wait_addr;
  logic [DW-1:0] cap_data, wait_data;
  logic [DW-1:0] exp_p0, exp_p1, rd_a, rd_b;
  logic          exp_first;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .p0_req_i(p0_req_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
    .p0_data_i(p0_data_i), .p0_data_o(p0_data_o), .p0_ack_o(p0_ack_o),
    .p1_req_i(p1_req_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
    .p1_data_i(p1_data_i), .p1_data_o(p1_data_o), .p1_ack_o(p1_ack_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always @(negedge clk) begin
    if (mem_enable_o) en_cnt <= en_cnt + 1;
    if (p1_ack_o) p1_ack_cnt <= p1_ack_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for ISSUE, records the memory request, then answers lat cycles after enable.
  task automatic serve(input int lat, input logic [DW-1:0] rd, input bit send_ack, input bit perturb);
    int n = 0;
    while (mem_enable_o !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check_eq("issue_seen", DW'(mem_enable_o), DW'(1));
    cap_write = mem_write_o;
    cap_addr  = mem_addr_o;
    cap_data  = mem_data_o;
    if (perturb) begin
      p0_addr_i  = ~p0_addr_i;
      p1_addr_i  = ~p1_addr_i;
      p1_data_i  = ~p1_data_i;
      p1_write_i = ~p1_write_i;
    end
    for (int i = 0; i < lat; i++) begin
      tick();
      if (i == 0) begin
        check_eq("wait_enable_low", DW'(mem_enable_o), DW'(0));
        wait_write = mem_write_o;
        wait_addr  = mem_addr_o;
        wait_data  = mem_data_o;
      end
    end
    if (send_ack) begin
      mem_ack_i  = 1'b1;
      mem_data_i = rd;
      tick();
      mem_ack_i  = 1'b0;
      mem_data_i = '0;
    end
  endtask

  initial begin
    int en0, a1;
    rst_i = 1'b1;
    p0_req_i = 0; p0_write_i = 0; p0_addr_i = '0; p0_data_i = '0;
    p1_req_i = 0; p1_write_i = 0; p1_addr_i = '0; p1_data_i = '0;
    mem_ack_i = 0; mem_data_i = '0;
    #2 rst_i = 1'b0;
    #1;
    check_eq("rst_busy", DW'(busy_o), DW'(0));
    check_eq("rst_enable", DW'(mem_enable_o), DW'(0));
    check_eq("rst_acks", DW'({p0_ack_o, p1_ack_o, timeout_o}), DW'(0));
    check_eq("rst_p0_data", p0_data_o, '0);
    tick(); tick();
    rst_i = 1'b1;
    tick();

    // Single read by p0, memory answers 3 cycles after enable.
    en0 = en_cnt; a1 = p1_ack_cnt;
    p0_req_i = 1; p0_write_i = 0; p0_addr_i = 32'h0000_0040;
    serve(3, {32{8'hA5}}, 1'b1, 1'b0);
    check_eq("rd_issue_addr", DW'(cap_addr), DW'(32'h40));
    check_eq("rd_issue_write", DW'(cap_write), DW'(0));
    check_eq("rd_p0_ack", DW'(p0_ack_o), DW'(1));
    check_eq("rd_timeout", DW'(timeout_o), DW'(0));
    check_eq("rd_p0_data", p0_data_o, {32{8'hA5}});
    p0_req_i = 0;
    tick();
    check_eq("rd_ack_pulse", DW'(p0_ack_o), DW'(0));
    check_eq("rd_idle_busy", DW'(busy_o), DW'(0));
    check_eq("rd_data_held", p0_data_o, {32{8'hA5}});
    check_eq("rd_enable_count", DW'(en_cnt - en0), DW'(1));
    check_eq("rd_p1_ack_count", DW'(p1_ack_cnt - a1), DW'(0));
    exp_p0 = {32{8'hA5}};
    $display("txn read p0 addr 0x40");

    // p1 write; inputs changed mid-flight must not leak into the access.
    p1_req_i = 1; p1_write_i = 1; p1_addr_i = 32'h0000_0100; p1_data_i = DW'(32'h1234);
    serve(2, '1, 1'b1, 1'b1);
    check_eq("wr_issue_write", DW'(cap_write), DW'(1));
    check_eq("wr_issue_addr", DW'(cap_addr), DW'(32'h100));
    check_eq("wr_issue_data", cap_data, DW'(32'h1234));
    check_eq("wr_wait_write", DW'(wait_write), DW'(1));
    check_eq("wr_wait_addr", DW'(wait_addr), DW'(32'h100));
    check_eq("wr_wait_data", wait_data, DW'(32'h1234));
    check_eq("wr_p1_ack", DW'({p1_ack_o, p0_ack_o}), DW'(2'b10));
    check_eq("wr_p1_data", p1_data_o, '0);
    p1_req_i = 0; p1_write_i = 0;
    tick();
    check_eq("wr_idle_bus", DW'({mem_write_o, mem_addr_o}), DW'(0));
    check_eq("wr_idle_data", mem_data_o, '0);
    exp_p1 = '0;
    $display("txn write p1 addr 0x100");

    // Simultaneous reads, each held until its own ack.
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    exp_first = 1'b0;
`else
    exp_first = 1'b1;
`endif
    rd_a = {8{32'h1111_1111}};
    rd_b = {8{32'h2222_2222}};
    p0_req_i = 1; p0_write_i = 0; p0_addr_i = 32'h200;
    p1_req_i = 1; p1_write_i = 0; p1_addr_i = 32'h300;
    serve(1, rd_a, 1'b1, 1'b0);
    check_eq("arb1_addr", DW'(cap_addr), exp_first ? DW'(32'h300) : DW'(32'h200));
    check_eq("arb1_acks", DW'({p1_ack_o, p0_ack_o}), exp_first ? DW'(2'b10) : DW'(2'b01));
    if (exp_first) p1_req_i = 0; else p0_req_i = 0;
    tick();
    check_eq("arb_gap_busy", DW'(busy_o), DW'(0));
    serve(1, rd_b, 1'b1, 1'b0);
    check_eq("arb2_addr", DW'(cap_addr), exp_first ? DW'(32'h200) : DW'(32'h300));
    check_eq("arb2_acks", DW'({p1_ack_o, p0_ack_o}), exp_first ? DW'(2'b01) : DW'(2'b10));
    exp_p0 = exp_first ? rd_b : rd_a;
    exp_p1 = exp_first ? rd_a : rd_b;
    check_eq("arb_p0_data", p0_data_o, exp_p0);
    check_eq("arb_p1_data", p1_data_o, exp_p1);
    p0_req_i = 0; p1_req_i = 0;
    tick();
    $display("txn tie first=p%0d", exp_first);

    // Timeout: no memory answer for 8 WAIT cycles, then a late ack.
    p0_req_i = 1; p0_addr_i = 32'h80;
    serve(8, '0, 1'b0, 1'b0);
    check_eq("to_wait8_busy", DW'(busy_o), DW'(1));
    check_eq("to_wait8_ack", DW'({p0_ack_o, timeout_o}), DW'(0));
    tick();
    check_eq("to_done", DW'({p0_ack_o, timeout_o, p1_ack_o}), DW'(3'b110));
    check_eq("to_p0_data", p0_data_o, exp_p0);
    p0_req_i = 0;
    mem_ack_i = 1; mem_data_i = '1;
    tick();
    check_eq("to_pulse", DW'({p0_ack_o, timeout_o}), DW'(0));
    tick();
    mem_ack_i = 0; mem_data_i = '0;
    check_eq("late_ack_idle", DW'({busy_o, mem_enable_o}), DW'(0));
    check_eq("late_ack_data", p0_data_o, exp_p0);
    $display("txn timeout p0 addr 0x80");

    // Ack on the last WAIT cycle beats the timeout.
    p0_req_i = 1; p0_addr_i = 32'h84;
    serve(8, {8{32'h0BAD_F00D}}, 1'b1, 1'b0);
    check_eq("edge_done", DW'({p0_ack_o, timeout_o}), DW'(2'b10));
    check_eq("edge_data", p0_data_o, {8{32'h0BAD_F00D}});
    p0_req_i = 0;
    tick();
    $display("txn ack-at-limit p0 addr 0x84");

    // Reset during WAIT, memory answers after release.
    p0_req_i = 1; p0_addr_i = 32'h40;
    serve(2, '0, 1'b0, 1'b0);
    rst_i = 1'b0;
    #1;
    check_eq("mrst_busy", DW'({busy_o, mem_enable_o, mem_write_o}), DW'(0));
    check_eq("mrst_addr", DW'(mem_addr_o), DW'(0));
    check_eq("mrst_p0_data", p0_data_o, '0);
    p0_req_i = 0;
    tick(); tick();
    rst_i = 1'b1;
    mem_ack_i = 1; mem_data_i = DW'(32'h77);
    tick();
    mem_ack_i = 0; mem_data_i = '0;
    check_eq("mrst_no_ack", DW'({p0_ack_o, p1_ack_o, busy_o}), DW'(0));
    check_eq("mrst_data_zero", p0_data_o, '0);
    p1_req_i = 1; p1_write_i = 0; p1_addr_i = 32'h500;
    serve(1, {32{8'h5A}}, 1'b1, 1'b0);
    check_eq("post_rst_addr", DW'(cap_addr), DW'(32'h500));
    check_eq("post_rst_ack", DW'({p1_ack_o, p0_ack_o}), DW'(2'b10));
    check_eq("post_rst_data", p1_data_o, {32{8'h5A}});
    p1_req_i = 0;
    tick();
    $display("txn reset-recovery p1 addr 0x500");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
